// File: rtl/servo_setpoint_encoder.sv
// Quadrature encoder + push-button front end producing an 8-bit servo position setpoint.
// Optional auto-sweep mode is built when SERVO_SWEEP_EN is defined.
module servo_setpoint_encoder #(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int STEP            = 4,
  parameter int POS_MAX         = 255,
  parameter int POS_CENTER      = 128
`ifdef SERVO_SWEEP_EN
  , parameter int SWEEP_DIV     = 200000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       enc_btn_n,
  output logic [7:0] setpoint,
  output logic       setpoint_valid,
  output logic       sweep_active
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Lane order {button, b, a}; the button idles released (high).
  localparam logic [2:0] RST_LVL = 3'b100;

  logic [2:0] raw, sync1, sync2, deb;
  logic [2:0][CNT_W-1:0] cnt;

  assign raw = {enc_btn_n, enc_b, enc_a};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= RST_LVL;
      sync2 <= RST_LVL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_deb
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt[i] <= '0;
        deb[i] <= RST_LVL[i];
      end else if (sync2[i] == deb[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt[i] <= '0;
        deb[i] <= sync2[i];
      end else begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  typedef enum logic [2:0] {IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3, RESYNC} state_t;
  state_t state, state_nxt;
  logic [1:0] ab;
  logic emit_up, emit_dn;

  assign ab = {deb[0], deb[1]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit_up   = 1'b0;
    emit_dn   = 1'b0;
    case (state)
      IDLE:   if (ab == 2'b01) state_nxt = CW1;
              else if (ab == 2'b10) state_nxt = CCW1;
              else if (ab == 2'b11) state_nxt = RESYNC;
      CW1:    if (ab == 2'b11) state_nxt = CW2;
              else if (ab == 2'b00) state_nxt = IDLE;
              else if (ab == 2'b10) state_nxt = RESYNC;
      CW2:    if (ab == 2'b10) state_nxt = CW3;
              else if (ab == 2'b01) state_nxt = CW1;
              else if (ab == 2'b00) state_nxt = RESYNC;
      CW3:    if (ab == 2'b00) begin state_nxt = IDLE; emit_up = 1'b1; end
              else if (ab == 2'b11) state_nxt = CW2;
              else if (ab == 2'b01) state_nxt = RESYNC;
      CCW1:   if (ab == 2'b11) state_nxt = CCW2;
              else if (ab == 2'b00) state_nxt = IDLE;
              else if (ab == 2'b01) state_nxt = RESYNC;
      CCW2:   if (ab == 2'b01) state_nxt = CCW3;
              else if (ab == 2'b10) state_nxt = CCW1;
              else if (ab == 2'b00) state_nxt = RESYNC;
      CCW3:   if (ab == 2'b00) begin state_nxt = IDLE; emit_dn = 1'b1; end
              else if (ab == 2'b11) state_nxt = CCW2;
              else if (ab == 2'b10) state_nxt = RESYNC;
      RESYNC: if (ab == 2'b00) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Steps are registered so the setpoint moves one clock after the emitting transition.
  logic step_up, step_dn, btn_q, press;
  always_ff @(posedge clk) begin
    if (reset) begin
      step_up <= 1'b0;
      step_dn <= 1'b0;
      btn_q   <= 1'b1;
    end else begin
      step_up <= emit_up;
      step_dn <= emit_dn;
      btn_q   <= deb[2];
    end
  end
  assign press = btn_q & ~deb[2];

  logic [8:0] sum_up;
  logic [7:0] up_val, dn_val, sp_nxt;
  assign sum_up = {1'b0, setpoint} + 9'(STEP);
  assign up_val = (sum_up > 9'(POS_MAX)) ? 8'(POS_MAX) : sum_up[7:0];
  assign dn_val = ({1'b0, setpoint} < 9'(STEP)) ? 8'd0 : setpoint - 8'(STEP);

`ifdef SERVO_SWEEP_EN
  localparam int PRE_W = $clog2(SWEEP_DIV + 1);
  logic [PRE_W-1:0] pre, pre_nxt;
  logic sweep, sweep_nxt, dir_up, dir_nxt;

  always_comb begin
    sp_nxt    = setpoint;
    sweep_nxt = sweep;
    dir_nxt   = dir_up;
    pre_nxt   = pre;
    if (press) begin
      sweep_nxt = ~sweep;
      pre_nxt   = '0;
      if (!sweep) dir_nxt = 1'b1;
    end else if (sweep) begin
      // Encoder steps are ignored while sweeping; only prescaler wraps move the setpoint.
      if (pre == PRE_W'(SWEEP_DIV - 1)) begin
        pre_nxt = '0;
        if (dir_up) begin
          sp_nxt = up_val;
          if (sum_up >= 9'(POS_MAX)) dir_nxt = 1'b0;
        end else begin
          sp_nxt = dn_val;
          if ({1'b0, setpoint} <= 9'(STEP)) dir_nxt = 1'b1;
        end
      end else begin
        pre_nxt = pre + 1'b1;
      end
    end else if (step_up) begin
      sp_nxt = up_val;
    end else if (step_dn) begin
      sp_nxt = dn_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre    <= '0;
      sweep  <= 1'b0;
      dir_up <= 1'b1;
    end else begin
      pre    <= pre_nxt;
      sweep  <= sweep_nxt;
      dir_up <= dir_nxt;
    end
  end
  assign sweep_active = sweep;
`else
  always_comb begin
    sp_nxt = setpoint;
    if (press)        sp_nxt = 8'(POS_CENTER);
    else if (step_up) sp_nxt = up_val;
    else if (step_dn) sp_nxt = dn_val;
  end
  assign sweep_active = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      setpoint       <= 8'(POS_CENTER);
      setpoint_valid <= 1'b0;
    end else begin
      setpoint       <= sp_nxt;
      setpoint_valid <= (sp_nxt != setpoint);
    end
  end

endmodule
